// File: rtl/bus_ctrl_sequencer.sv
// bus_ctrl_sequencer: cycle-stepped control unit for the datapath bus.
// Fetches one instruction (T0..T2) and then, for three-register ALU ops
// (opcode 0-11), immediate ALU ops (12-14) and ldi (15), drives the execute
// strobes (T3..T5). Opcodes above 15 take a single ILL cycle instead.
//
// Ports:
//   clock, clear_n        - clock (rising edge), asynchronous active-low clear
//   start                 - run one instruction; only looked at in IDLE
//   mem_ready             - memory read data valid this cycle
//   ir[31:0]              - opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15]
//   R_out, R_in [15:0]    - one-hot register drive / load strobes
//   PCout .. BAout        - single-bit datapath strobes
//   alu_op[4:0]           - ALU operation, meaningful only with Zin
//   busy, done, illegal   - status: T0..T5 / completion pulse / bad opcode pulse
module bus_ctrl_sequencer (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        start,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic [15:0] R_out,
  output logic [15:0] R_in,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Cout,
  output logic        BAout,
  output logic [4:0]  alu_op,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [2:0] {
    StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StIll
  } state_e;

  state_e state_q, state_d;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       unused_ir;

  assign opcode    = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  // The constant field C is consumed by the datapath, not by this sequencer.
  assign unused_ir = ^ir[14:0];

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StT0;
      StT0:    state_d = StT1;
      StT1:    if (mem_ready) state_d = StT2;
      StT2:    state_d = (opcode <= 5'd15) ? StT3 : StIll;
      StT3:    state_d = StT4;
      StT4:    state_d = StT5;
      StT5:    state_d = StIdle;
      StIll:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // IDLE decodes to all-zero, so the asynchronous clear zeroes every output.
  always_comb begin
    R_out   = '0;
    R_in    = '0;
    PCout   = 1'b0;
    PCin    = 1'b0;
    IncPC   = 1'b0;
    MARin   = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    Read    = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    Zin     = 1'b0;
    Zlowout = 1'b0;
    Cout    = 1'b0;
    BAout   = 1'b0;
    alu_op  = 5'd0;
    busy    = 1'b0;
    done    = 1'b0;
    illegal = 1'b0;
    unique case (state_q)
      StT0: begin
        busy  = 1'b1;
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      StT1: begin
        // PC and MDR load only on the data-valid cycle, so PC advances once.
        busy    = 1'b1;
        Zlowout = 1'b1;
        Read    = 1'b1;
        PCin    = mem_ready;
        MDRin   = mem_ready;
      end
      StT2: begin
        busy   = 1'b1;
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      StT3: begin
        busy  = 1'b1;
        R_out = 16'h0001 << rb;
        Yin   = 1'b1;
        // ldi relies on Rb=0 turning the bus into a constant zero.
        BAout = (opcode == 5'd15);
      end
      StT4: begin
        busy = 1'b1;
        Zin  = 1'b1;
        if (opcode <= 5'd11) begin
          R_out  = 16'h0001 << rc;
          alu_op = opcode;
        end else begin
          Cout = 1'b1;
          unique case (opcode)
            5'd13:   alu_op = 5'd2;
            5'd14:   alu_op = 5'd3;
            default: alu_op = 5'd0;  // addi and ldi both add
          endcase
        end
      end
      StT5: begin
        busy    = 1'b1;
        Zlowout = 1'b1;
        R_in    = 16'h0001 << ra;
        done    = 1'b1;
      end
      StIll: begin
        illegal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_ctrl_sequencer.sv
// Bench for bus_ctrl_sequencer. Each instruction run is expanded from the
// instruction word into a per-cycle schedule of inputs and expected outputs,
// which is then played against the DUT and compared cycle by cycle.
module tb_bus_ctrl_sequencer;

  logic        clock;
  logic        clear_n;
  logic        start;
  logic        mem_ready;
  logic [31:0] ir;
  logic [15:0] R_out, R_in;
  logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin;
  logic        Yin, Zin, Zlowout, Cout, BAout;
  logic [4:0]  alu_op;
  logic        busy, done, illegal;

  bus_ctrl_sequencer dut (
    .clock     (clock),
    .clear_n   (clear_n),
    .start     (start),
    .mem_ready (mem_ready),
    .ir        (ir),
    .R_out     (R_out),
    .R_in      (R_in),
    .PCout     (PCout),
    .PCin      (PCin),
    .IncPC     (IncPC),
    .MARin     (MARin),
    .MDRin     (MDRin),
    .MDRout    (MDRout),
    .Read      (Read),
    .IRin      (IRin),
    .Yin       (Yin),
    .Zin       (Zin),
    .Zlowout   (Zlowout),
    .Cout      (Cout),
    .BAout     (BAout),
    .alu_op    (alu_op),
    .busy      (busy),
    .done      (done),
    .illegal   (illegal)
  );

  typedef struct packed {
    logic [15:0] r_out;
    logic [15:0] r_in;
    logic        pcout, pcin, incpc, marin, mdrin, mdrout, read, irin;
    logic        yin, zin, zlowout, cout, baout;
    logic [4:0]  alu_op;
    logic        busy, done, illegal;
  } outs_t;

  typedef struct {
    logic  st;
    logic  mr;
    outs_t exp;
    string tag;
  } step_t;

  step_t q[$];
  int    checks   = 0;
  int    errors   = 0;
  int    done_cnt = 0;
  int    exp_done = 0;
  logic  run_legal;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (done === 1'b1) done_cnt++;

  function automatic outs_t observe();
    outs_t o;
    o.r_out = R_out;    o.r_in = R_in;
    o.pcout = PCout;    o.pcin = PCin;     o.incpc = IncPC;   o.marin = MARin;
    o.mdrin = MDRin;    o.mdrout = MDRout; o.read = Read;     o.irin = IRin;
    o.yin = Yin;        o.zin = Zin;       o.zlowout = Zlowout;
    o.cout = Cout;      o.baout = BAout;   o.alu_op = alu_op;
    o.busy = busy;      o.done = done;     o.illegal = illegal;
    return o;
  endfunction

  task automatic check(input string tag, input outs_t obs, input outs_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic st, input logic mr, input outs_t o, input string tag);
    step_t s;
    s.st = st; s.mr = mr; s.exp = o; s.tag = tag;
    q.push_back(s);
  endtask

  // Expand one instruction into its cycle schedule. Stray start pulses are
  // scattered through the busy cycles; they must have no effect.
  task automatic build(input logic [31:0] ins, input int waits);
    outs_t o;
    int opc = int'(ins[31:27]);
    int ra  = int'(ins[26:23]);
    int rb  = int'(ins[22:19]);
    int rc  = int'(ins[18:15]);
    q.delete();
    push(1'b1, 1'($urandom_range(0, 1)), '0, "idle_start");
    o = '0; o.busy = 1; o.pcout = 1; o.marin = 1; o.incpc = 1; o.zin = 1;
    push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o, "T0");
    for (int w = 0; w < waits; w++) begin
      o = '0; o.busy = 1; o.zlowout = 1; o.read = 1;
      push(1'($urandom_range(0, 1)), 1'b0, o, "T1_wait");
    end
    o = '0; o.busy = 1; o.zlowout = 1; o.read = 1; o.pcin = 1; o.mdrin = 1;
    push(1'($urandom_range(0, 1)), 1'b1, o, "T1_ready");
    o = '0; o.busy = 1; o.mdrout = 1; o.irin = 1;
    push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o, "T2");
    run_legal = (opc <= 15);
    if (!run_legal) begin
      o = '0; o.illegal = 1;
      push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o, "ILL");
    end else begin
      o = '0; o.busy = 1; o.yin = 1; o.r_out = 16'(1) << rb; o.baout = (opc == 15);
      push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o, "T3");
      o = '0; o.busy = 1; o.zin = 1;
      if (opc <= 11) begin
        o.r_out = 16'(1) << rc;
        o.alu_op = 5'(opc);
      end else begin
        o.cout = 1;
        o.alu_op = (opc == 13) ? 5'd2 : (opc == 14) ? 5'd3 : 5'd0;
      end
      push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o, "T4");
      o = '0; o.busy = 1; o.zlowout = 1; o.done = 1; o.r_in = 16'(1) << ra;
      push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o, "T5");
    end
    push(1'b0, 1'($urandom_range(0, 1)), '0, "idle_after");
  endtask

  // abort_at >= 0 drops clear_n mid-cycle at that schedule index.
  task automatic run(input logic [31:0] ins, input int waits, input int abort_at);
    build(ins, waits);
    ir = ins;
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clock);
      #1;
      start     = q[i].st;
      mem_ready = q[i].mr;
      if (i == abort_at) begin
        #1 clear_n = 1'b0;
        #1 check("async_clear", observe(), '0);
        start = 1'b0;
        @(posedge clock);
        #1 check("held_clear", observe(), '0);
        @(negedge clock);
        clear_n = 1'b1;
        @(posedge clock);
        #1 check("post_clear_idle", observe(), '0);
        return;
      end
      @(negedge clock);
      check(q[i].tag, observe(), q[i].exp);
    end
    if (run_legal) exp_done++;
  endtask

  initial begin
    clear_n   = 1'b0;
    start     = 1'b0;
    mem_ready = 1'b0;
    ir        = '0;
    #1 check("reset", observe(), '0);
    #12 clear_n = 1'b1;

    run(32'h0189_0000, 0, -1);  // add R3,R1,R2
    run(32'h0189_0000, 3, -1);  // same, three memory wait cycles
    run(32'h7A80_0010, 0, -1);  // ldi R5,0x10(R0)
    run(32'hA000_0000, 0, -1);  // opcode 20
    run(32'h0189_0000, 0, 5);   // clear during T4
    run(32'h0189_0000, 1, 2);   // clear during T1
    run(32'h6000_0000, 0, -1);  // addi R0 -> R_in bit 0
    run(32'hF000_0000, 0, -1);  // opcode 30, illegal

    for (int n = 0; n < 40; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      if ($urandom_range(0, 3) != 0) ins[31] = 1'b0;
      run(ins, int'($urandom_range(0, 3)), -1);
    end

    check_int("done_count", done_cnt, exp_done);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
